// File: rtl/mmu_lsu_if.sv
// Request/response bus between a load/store requester and the mmu_lsu data memory.
interface mmu_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  op;
  logic                  rw;
  logic [1:0]            size;
  logic                  sign;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  ready;
  logic                  done;
  logic [1:0]            fault;
  logic [DATA_WIDTH-1:0] data_r;

  modport master (
    output op, rw, size, sign, addr, data_w,
    input  ready, done, fault, data_r
  );

  modport slave (
    input  op, rw, size, sign, addr, data_w,
    output ready, done, fault, data_r
  );
endinterface

// File: rtl/mmu_lsu.sv
// Byte-addressed data memory with sized, sign-aware loads/stores,
// programmable access latency and fault reporting (IDLE/BUSY/RESP handshake).
module mmu_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int SIZE       = 256,
  parameter int LATENCY    = 1
) (
  input logic     sys_clk,
  input logic     sys_rst,
  mmu_lsu_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int WORDS = SIZE / BYTES;
  localparam int SHIFT = $clog2(BYTES);
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] SIZE_L   = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [1:0]            fault_q, fault_nxt;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  rw_p0;
  logic [1:0]            size_p0;
  logic                  sign_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [OFF_W-1:0]      off_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  accept;
  logic                  commit;
  logic [1:0]            req_fault;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata_sh;

  // Priority: bad size, then misaligned, then out of range (no wrap at ADDR_WIDTH+1 bits).
  function automatic logic [1:0] check_fault(input logic [1:0] sz,
                                             input logic [ADDR_WIDTH-1:0] a);
    int                  nbytes;
    logic [ADDR_WIDTH:0] end_a;
    nbytes = 1 << sz;
    end_a  = {1'b0, a} + (ADDR_WIDTH+1)'(nbytes);
    if (nbytes > BYTES) return 2'd3;
    if ((a & ADDR_WIDTH'(nbytes - 1)) != '0) return 2'd1;
    if (end_a > SIZE_L) return 2'd2;
    return 2'd0;
  endfunction

  // Right-align the addressed lanes and sign- or zero-extend to the full word.
  function automatic logic [DATA_WIDTH-1:0] load_align(input logic [DATA_WIDTH-1:0] word,
                                                       input logic [OFF_W-1:0]      off,
                                                       input logic [1:0]            sz,
                                                       input logic                  sgn);
    logic [DATA_WIDTH-1:0]        sh;
    logic signed [DATA_WIDTH-1:0] t;
    int                           nbits;
    int                           k;
    sh    = word >> (int'(off) * BYTE_WIDTH);
    nbits = BYTE_WIDTH << sz;
    if (nbits >= DATA_WIDTH) return sh;
    k = DATA_WIDTH - nbits;
    t = signed'(sh << k);
    if (sgn) return $unsigned(t >>> k);
    return (sh << k) >> k;
  endfunction

  // Lanes touched by an access of 2**sz bytes starting at lane off.
  function automatic logic [BYTES-1:0] lane_enable(input logic [OFF_W-1:0] off,
                                                   input logic [1:0]       sz);
    logic [BYTES-1:0] en;
    int               nbytes;
    nbytes = 1 << sz;
    en     = '0;
    for (int i = 0; i < BYTES; i++) begin
      en[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
    end
    return en;
  endfunction

  assign accept    = bus.op && (state != S_BUSY);
  assign req_fault = check_fault(bus.size, bus.addr);
  assign commit    = (state == S_BUSY) && (cnt == 4'd0);
  assign be        = lane_enable(off_p0, size_p0);
  assign wdata_sh  = wdata_p0 << (int'(off_p0) * BYTE_WIDTH);

  assign bus.ready  = (state != S_BUSY);
  assign bus.done   = (state == S_RESP);
  assign bus.fault  = fault_q;
  assign bus.data_r = rdata_q;

  // Next-state logic; a faulted request skips BUSY and answers in the following cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fault_nxt = 2'd0;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (bus.op) begin
          if (req_fault != 2'd0) begin
            state_nxt = S_RESP;
            fault_nxt = req_fault;
          end else begin
            state_nxt = S_BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end else if (state == S_RESP) begin
          state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state, fault code and load result register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      fault_q <= 2'd0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      fault_q <= fault_nxt;
      if (commit && !rw_p0) rdata_q <= load_align(mem[idx_p0], off_p0, size_p0, sign_p0);
    end
  end

  // Stage p0: request fields captured at acceptance, held through BUSY.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      rw_p0    <= bus.rw;
      size_p0  <= bus.size;
      sign_p0  <= bus.sign;
      idx_p0   <= IDX_W'(bus.addr >> SHIFT);
      off_p0   <= OFF_W'(bus.addr & ADDR_WIDTH'(BYTES - 1));
      wdata_p0 <= bus.data_w;
    end
  end

  // Store commit: only enabled lanes are written; a reset on the commit edge drops it.
  always_ff @(posedge sys_clk) begin
    if (commit && rw_p0 && !sys_rst) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[idx_p0][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_sh[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mmu_lsu.sv
// Directed bench for mmu_lsu: LATENCY=1 instance for functional/fault vectors,
// LATENCY=4 instance for busy timing, back-to-back throughput and reset mid-store.
module tb_mmu_lsu;

  logic clk = 1'b0;
  logic rst1;
  logic rst4;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mmu_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  mmu_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus4 ();

  mmu_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(256), .LATENCY(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst1), .bus(bus1));

  mmu_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(256), .LATENCY(4)) dut4 (
    .sys_clk(clk), .sys_rst(rst4), .bus(bus4));

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_fault;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] ef, input logic [31:0] erd);
    vec_t v;
    v.rw = rw; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.exp_fault = ef; v.exp_rd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_req(input int d, input logic op, input logic rw, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] data);
    if (d == 1) begin
      bus1.op = op; bus1.rw = rw; bus1.size = size; bus1.sign = sign;
      bus1.addr = addr; bus1.data_w = data;
    end else begin
      bus4.op = op; bus4.rw = rw; bus4.size = size; bus4.sign = sign;
      bus4.addr = addr; bus4.data_w = data;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 1) ? bus1.ready : bus4.ready;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 1) ? bus1.done : bus4.done;
  endfunction

  function automatic logic [1:0] get_fault(input int d);
    return (d == 1) ? bus1.fault : bus4.fault;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 1) ? bus1.data_r : bus4.data_r;
  endfunction

  // Issue one request, wait for acceptance and for done; lat = edges from acceptance to done.
  task automatic do_op(input int d, input logic rw, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd, output logic [1:0] flt, output int lat);
    int n;
    n = 0;
    set_req(d, 1'b1, rw, size, sign, addr, data);
    while (!get_ready(d) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    set_req(d, 1'b0, rw, size, sign, addr, data);
    n = 0;
    while (!get_done(d) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("done_timeout", 32'(n), 32'd0);
    rd  = get_rdata(d);
    flt = get_fault(d);
    lat = n;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  flt;
    int          lat;

    vecs[0]  = mk(1, 2, 0, 32'h10,       32'h11223344, 0, 32'h0000003F);
    vecs[1]  = mk(1, 0, 0, 32'h12,       32'hFFFFFFF0, 0, 32'h0000003F);
    vecs[2]  = mk(0, 2, 0, 32'h10,       32'h0,        0, 32'h11F03344);
    vecs[3]  = mk(0, 0, 1, 32'h12,       32'h0,        0, 32'hFFFFFFF0);
    vecs[4]  = mk(0, 0, 0, 32'h12,       32'h0,        0, 32'h000000F0);
    vecs[5]  = mk(0, 0, 1, 32'h11,       32'h0,        0, 32'h00000033);
    vecs[6]  = mk(0, 0, 0, 32'h13,       32'h0,        0, 32'h00000011);
    vecs[7]  = mk(0, 1, 1, 32'h10,       32'h0,        0, 32'h00003344);
    vecs[8]  = mk(1, 1, 0, 32'h22,       32'hABCD8001, 0, 32'h00003344);
    vecs[9]  = mk(0, 1, 1, 32'h22,       32'h0,        0, 32'hFFFF8001);
    vecs[10] = mk(0, 1, 0, 32'h22,       32'h0,        0, 32'h00008001);
    vecs[11] = mk(0, 2, 0, 32'h20,       32'h0,        0, 32'h80010008);
    vecs[12] = mk(0, 1, 1, 32'h3,        32'h0,        1, 32'h80010008);
    vecs[13] = mk(1, 2, 0, 32'hFC,       32'hA5A5A5A5, 0, 32'h80010008);
    vecs[14] = mk(0, 2, 0, 32'hFC,       32'h0,        0, 32'hA5A5A5A5);
    vecs[15] = mk(1, 2, 0, 32'h100,      32'h12345678, 2, 32'hA5A5A5A5);
    vecs[16] = mk(1, 3, 0, 32'h8,        32'h0000DEAD, 3, 32'hA5A5A5A5);
    vecs[17] = mk(1, 2, 0, 32'h6,        32'h00000055, 1, 32'hA5A5A5A5);
    vecs[18] = mk(1, 2, 0, 32'hFFFFFFFC, 32'h77777777, 2, 32'hA5A5A5A5);
    vecs[19] = mk(0, 1, 0, 32'hFF,       32'h0,        1, 32'hA5A5A5A5);
    vecs[20] = mk(0, 3, 0, 32'h3,        32'h0,        3, 32'hA5A5A5A5);
    vecs[21] = mk(0, 2, 0, 32'h0,        32'h0,        0, 32'h00000000);
    vecs[22] = mk(0, 2, 0, 32'h8,        32'h0,        0, 32'h00000002);
    vecs[23] = mk(0, 2, 0, 32'h4,        32'h0,        0, 32'h00000001);
    vecs[24] = mk(0, 0, 0, 32'hFF,       32'h0,        0, 32'h000000A5);

    rst1 = 1'b1;
    rst4 = 1'b1;
    set_req(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    set_req(4, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst4 = 1'b0;

    check("rst1_ready", 32'(bus1.ready), 32'd1);
    check("rst1_done",  32'(bus1.done),  32'd0);
    check("rst1_fault", 32'(bus1.fault), 32'd0);
    check("rst1_data_r", bus1.data_r,    32'd0);
    check("rst4_ready", 32'(bus4.ready), 32'd1);
    check("rst4_done",  32'(bus4.done),  32'd0);
    check("rst4_data_r", bus4.data_r,    32'd0);

    // Word round trip
    for (int i = 0; i < 64; i++) begin
      do_op(1, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'(i), rd, flt, lat);
      check($sformatf("rt_sw%0d_fault", i), 32'(flt), 32'd0);
      check($sformatf("rt_sw%0d_lat", i), 32'(lat), 32'd1);
    end
    for (int i = 0; i < 64; i++) begin
      do_op(1, 1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0, rd, flt, lat);
      check($sformatf("rt_lw%0d_data", i), rd, 32'(i));
      check($sformatf("rt_lw%0d_fault", i), 32'(flt), 32'd0);
      check($sformatf("rt_lw%0d_lat", i), 32'(lat), 32'd1);
    end

    // Sized access, merge, sign extension and fault vectors
    for (int v = 0; v < 25; v++) begin
      do_op(1, vecs[v].rw, vecs[v].size, vecs[v].sign, vecs[v].addr, vecs[v].wdata, rd, flt, lat);
      check($sformatf("vec%0d_data_r", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_fault", v), 32'(flt), 32'(vecs[v].exp_fault));
      check($sformatf("vec%0d_lat", v), 32'(lat), (vecs[v].exp_fault != 2'd0) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    check("idle_done", 32'(bus1.done), 32'd0);
    check("idle_fault", 32'(bus1.fault), 32'd0);

    // LATENCY=4: seed a word
    do_op(4, 1'b1, 2'd2, 1'b0, 32'h40, 32'h01020304, rd, flt, lat);
    check("l4_sw_fault", 32'(flt), 32'd0);
    check("l4_sw_lat", 32'(lat), 32'd4);

    // Reset mid-store: accepted in the RESP cycle, reset sampled at E2
    set_req(4, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    set_req(4, 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    check("rstmid_busy_ready", 32'(bus4.ready), 32'd0);
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    check("rstmid_ready", 32'(bus4.ready), 32'd1);
    check("rstmid_done", 32'(bus4.done), 32'd0);
    check("rstmid_fault", 32'(bus4.fault), 32'd0);
    do_op(4, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, flt, lat);
    check("rstmid_lw_data", rd, 32'h01020304);
    check("rstmid_lw_lat", 32'(lat), 32'd4);

    // Back-to-back loads with op held/toggled; expected 5-cycle period
    @(posedge clk); #1;
    set_req(4, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    for (int s = 0; s < 10; s++) begin
      check($sformatf("b2b_s%0d_ready", s), 32'(bus4.ready), (s == 4 || s == 9) ? 32'd1 : 32'd0);
      check($sformatf("b2b_s%0d_done", s), 32'(bus4.done), (s == 4 || s == 9) ? 32'd1 : 32'd0);
      if (s == 4 || s == 9) check($sformatf("b2b_s%0d_data", s), bus4.data_r, 32'h01020304);
      bus4.op = (s == 4) ? 1'b1 : (s == 9) ? 1'b0 : 1'(s % 2);
      @(posedge clk); #1;
    end
    check("b2b_end_ready", 32'(bus4.ready), 32'd1);
    check("b2b_end_done", 32'(bus4.done), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
